// File: rtl/dat_write_sequencer.sv
// dat_write_sequencer: drives the dat_write datapath through a multi-block SD write.
// It waits for a full block in the host buffer, starts dat_write, feeds it 32-bit
// words on request, counts blocks, inserts the inter-block gap and ends the
// transfer on error, stop request or final block.
module dat_write_sequencer #(
    parameter int MaxBlockBitSize = 12,
    parameter int GapClks         = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sd_clk_en_i,
    input  logic                       start_i,
    input  logic [15:0]                block_count_i,
    input  logic                       stop_i,
    input  logic                       block_ready_i,
    input  logic [31:0]                word_i,
    input  logic                       word_valid_i,
    output logic                       word_ready_o,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    output logic                       dw_start_o,
    output logic [31:0]                dw_data_o,
    input  logic                       dw_next_word_i,
    input  logic                       dw_done_i,
    input  logic                       dw_crc_err_i,
    input  logic                       dw_end_bit_err_i,
    output logic                       busy_o,
    output logic                       block_done_o,
    output logic [15:0]                blocks_left_o,
    output logic                       xfer_done_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o,
    output logic                       underrun_err_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_BLK = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_ACTIVE   = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int GapW = (GapClks > 1) ? $clog2(GapClks) : 1;

    logic [2:0]                 state;
    logic [MaxBlockBitSize-1:0] word_cnt;
    logic [MaxBlockBitSize-1:0] block_words;
    logic [GapW-1:0]            gap_cnt;
    logic                       stop_pend;
    logic                       open_ended;
    logic                       blk_underrun;
    logic                       words_full;
    logic                       load_first;
    logic                       next_pop;
    logic                       underrun_now;
    logic                       blk_err;

    // Request decode: word counting guards against dat_write's trailing extra request
    always_comb begin
        block_words  = {2'b00, block_size_i[MaxBlockBitSize-1:2]};
        words_full   = (word_cnt >= block_words);
        load_first   = (state == S_WAIT_BLK) && !stop_i && block_ready_i && word_valid_i;
        next_pop     = (state == S_ACTIVE) && dw_next_word_i && !words_full && word_valid_i;
        underrun_now = (state == S_ACTIVE) && dw_next_word_i && !words_full && !word_valid_i;
        blk_err      = dw_crc_err_i || dw_end_bit_err_i || blk_underrun || underrun_now;
        word_ready_o = load_first || next_pop;
        dw_start_o   = (state == S_START);
        busy_o       = (state != S_IDLE);
        xfer_done_o  = (state == S_DONE);
    end

    // Transfer state machine, word holding register, block counter and sticky errors
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            word_cnt       <= '0;
            gap_cnt        <= '0;
            stop_pend      <= 1'b0;
            open_ended     <= 1'b0;
            blk_underrun   <= 1'b0;
            dw_data_o      <= '0;
            block_done_o   <= 1'b0;
            blocks_left_o  <= '0;
            crc_err_o      <= 1'b0;
            end_bit_err_o  <= 1'b0;
            underrun_err_o <= 1'b0;
        end else begin
            block_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start_i) begin
                        blocks_left_o  <= block_count_i;
                        open_ended     <= (block_count_i == 16'd0);
                        crc_err_o      <= 1'b0;
                        end_bit_err_o  <= 1'b0;
                        underrun_err_o <= 1'b0;
                        state          <= S_WAIT_BLK;
                    end
                end
                S_WAIT_BLK: begin
                    if (stop_i) begin
                        state <= S_DONE;
                    end else if (load_first) begin
                        dw_data_o    <= word_i;
                        word_cnt     <= {{(MaxBlockBitSize-1){1'b0}}, 1'b1};
                        blk_underrun <= 1'b0;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (sd_clk_en_i) state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (next_pop) begin
                        dw_data_o <= word_i;
                        word_cnt  <= word_cnt + 1'b1;
                    end
                    if (underrun_now) begin
                        underrun_err_o <= 1'b1;
                        blk_underrun   <= 1'b1;
                    end
                    if (dw_done_i) begin
                        if (dw_crc_err_i)     crc_err_o     <= 1'b1;
                        if (dw_end_bit_err_i) end_bit_err_o <= 1'b1;
                        if (blocks_left_o != 16'd0) blocks_left_o <= blocks_left_o - 16'd1;
                        block_done_o <= !blk_err;
                        gap_cnt      <= '0;
                        if (blk_err || stop_pend || stop_i ||
                            (!open_ended && blocks_left_o == 16'd1))
                            state <= S_DONE;
                        else
                            state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (stop_i) begin
                        state <= S_DONE;
                    end else if (sd_clk_en_i) begin
                        if (gap_cnt == GapW'(GapClks - 1))
                            state <= S_WAIT_BLK;
                        else
                            gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_write_sequencer.sv
// Testbench for dat_write_sequencer: host buffer model, dat_write behavioural
// model and a word scoreboard, with one task per scenario.
module tb_dat_write_sequencer;

    logic        clk, rst_i, sd_clk_en_i, start_i, stop_i, block_ready_i;
    logic        word_valid_i, word_ready_o, dw_start_o, dw_next_word_i, dw_done_i;
    logic        dw_crc_err_i, dw_end_bit_err_i, busy_o, block_done_o, xfer_done_o;
    logic        crc_err_o, end_bit_err_o, underrun_err_o;
    logic [15:0] block_count_i, blocks_left_o;
    logic [31:0] word_i, dw_data_o;
    logic [11:0] block_size_i;

    int tests, fails;
    int bd_cnt, xd_cnt, pop_cnt, model_blk, req_in_blk;
    int model_words, underrun_req, crc_block;
    bit hold_valid, blk_hold, model_abort, model_busy, pop_now;
    logic [31:0] buf_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] left_log[$];

    dat_write_sequencer #(.MaxBlockBitSize(12), .GapClks(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .sd_clk_en_i(sd_clk_en_i), .start_i(start_i),
        .block_count_i(block_count_i), .stop_i(stop_i), .block_ready_i(block_ready_i),
        .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
        .block_size_i(block_size_i), .dw_start_o(dw_start_o), .dw_data_o(dw_data_o),
        .dw_next_word_i(dw_next_word_i), .dw_done_i(dw_done_i), .dw_crc_err_i(dw_crc_err_i),
        .dw_end_bit_err_i(dw_end_bit_err_i), .busy_o(busy_o), .block_done_o(block_done_o),
        .blocks_left_o(blocks_left_o), .xfer_done_o(xfer_done_o), .crc_err_o(crc_err_o),
        .end_bit_err_o(end_bit_err_o), .underrun_err_o(underrun_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SD tick every other system clock
    initial begin
        sd_clk_en_i = 1'b0;
        forever begin
            @(posedge clk);
            #1 sd_clk_en_i = ~sd_clk_en_i;
        end
    end

    function automatic void update_feed();
        word_valid_i  = (buf_q.size() > 0) && !hold_valid;
        word_i        = (buf_q.size() > 0) ? buf_q[0] : 32'h0;
        block_ready_i = (buf_q.size() >= model_words) && !blk_hold;
    endfunction

    // Host buffer: pops on valid & ready at each clock edge
    initial begin
        word_valid_i = 1'b0; word_i = 32'h0; block_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            pop_now = word_valid_i && word_ready_o;
            #1;
            if (pop_now && buf_q.size() > 0) begin
                void'(buf_q.pop_front());
                pop_cnt++;
            end
            update_feed();
            @(negedge clk);
            #1 update_feed();
        end
    end

    // Pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (block_done_o) begin
                bd_cnt++;
                left_log.push_back(blocks_left_o);
            end
            if (xfer_done_o) xd_cnt++;
        end
    end

    task automatic wait_tick();
        @(negedge clk);
        while (!sd_clk_en_i) @(negedge clk);
    endtask

    // dat_write model: consumes model_words words per block, then one extra request, then done
    task automatic run_block();
        logic [31:0] e;
        bit skip;
        model_busy = 1'b1;
        model_blk++;
        req_in_blk = 0;
        skip = 1'b0;
        wait_tick();
        if (!model_abort) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL first_word: scoreboard empty, dw_data_o=%h", dw_data_o);
            end else begin
                e = exp_q.pop_front();
                if (dw_data_o !== e) begin
                    fails++;
                    $display("FAIL first_word: got %h, expected %h", dw_data_o, e);
                end
            end
        end
        for (int w = 2; w <= model_words + 1 && !model_abort; w++) begin
            wait_tick();
            wait_tick();
            if (model_abort) break;
            req_in_blk++;
            dw_next_word_i = 1'b1;
            if (req_in_blk == underrun_req) begin
                hold_valid = 1'b1;
                skip = 1'b1;
            end
            @(negedge clk);
            dw_next_word_i = 1'b0;
            hold_valid = 1'b0;
            if (!model_abort && !skip && w <= model_words) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_%0d: scoreboard empty, dw_data_o=%h", w, dw_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (dw_data_o !== e) begin
                        fails++;
                        $display("FAIL word_%0d: got %h, expected %h", w, dw_data_o, e);
                    end
                end
            end
        end
        if (!model_abort) begin
            wait_tick();
            wait_tick();
            if (!model_abort) begin
                dw_done_i = 1'b1;
                dw_crc_err_i = (model_blk == crc_block);
                @(negedge clk);
                dw_done_i = 1'b0;
                dw_crc_err_i = 1'b0;
            end
        end
        model_busy = 1'b0;
    endtask

    initial begin
        dw_next_word_i = 1'b0; dw_done_i = 1'b0; dw_crc_err_i = 1'b0; dw_end_bit_err_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!model_abort && !rst_i && dw_start_o && sd_clk_en_i) run_block();
        end
    end

    task automatic load_buf(input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            buf_q.push_back(v);
            exp_q.push_back(v);
        end
        @(negedge clk);
    endtask

    task automatic flush_buf();
        buf_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] cnt);
        @(negedge clk);
        block_count_i = cnt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_xfer(input int xd0, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        while (xd_cnt == xd0) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                to = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({word_ready_o, dw_start_o, busy_o, block_done_o, xfer_done_o,
             crc_err_o, end_bit_err_o, underrun_err_o} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 00000000", {word_ready_o, dw_start_o,
                     busy_o, block_done_o, xfer_done_o, crc_err_o, end_bit_err_o, underrun_err_o});
        end
        tests++;
        if (dw_data_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h, expected 0", dw_data_o);
        end
        tests++;
        if (blocks_left_o !== 16'h0) begin
            fails++;
            $display("FAIL reset_blocks_left: got %0d, expected 0", blocks_left_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy_o=%b, expected 0", busy_o);
        end
    endtask

    task automatic test_three_blocks();
        int bd0, xd0, p0, l0;
        bit to;
        block_size_i = 12'd512;
        model_words = 128;
        load_buf(384);
        bd0 = bd_cnt; xd0 = xd_cnt; p0 = pop_cnt; l0 = left_log.size();
        do_start(16'd3);
        tests++;
        if (blocks_left_o !== 16'd3) begin
            fails++;
            $display("FAIL three_latch_count: got %0d, expected 3", blocks_left_o);
        end
        wait_xfer(xd0, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL three_timeout: xfer_done_o not seen, expected 1 pulse");
        end
        tests++;
        if (bd_cnt - bd0 != 3) begin
            fails++;
            $display("FAIL three_block_done: got %0d pulses, expected 3", bd_cnt - bd0);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (left_log.size() <= l0 + i || left_log[l0 + i] !== 16'(2 - i)) begin
                fails++;
                $display("FAIL three_blocks_left_%0d: got %0d, expected %0d", i,
                         (left_log.size() > l0 + i) ? left_log[l0 + i] : 16'hffff, 2 - i);
            end
        end
        tests++;
        if (pop_cnt - p0 != 384) begin
            fails++;
            $display("FAIL three_pops: got %0d, expected 384", pop_cnt - p0);
        end
        tests++;
        if (xd_cnt - xd0 != 1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL three_xfer_done: got %0d pulses busy=%b, expected 1 busy=0", xd_cnt - xd0, busy_o);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL three_scoreboard: %0d words unconsumed, expected 0", exp_q.size());
        end
        flush_buf();
    endtask

    task automatic test_block_ready_late();
        int bd0, xd0, p0;
        bit to, seen;
        block_size_i = 12'd16;
        model_words = 4;
        blk_hold = 1'b1;
        load_buf(4);
        bd0 = bd_cnt; xd0 = xd_cnt; p0 = pop_cnt;
        do_start(16'd1);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (dw_start_o) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL late_no_start: dw_start_o seen=%b, expected 0", seen);
        end
        tests++;
        if (pop_cnt - p0 != 0) begin
            fails++;
            $display("FAIL late_no_pop: got %0d pops, expected 0", pop_cnt - p0);
        end
        blk_hold = 1'b0;
        wait_xfer(xd0, to);
        tests++;
        if (to || bd_cnt - bd0 != 1 || pop_cnt - p0 != 4) begin
            fails++;
            $display("FAIL late_complete: timeout=%b blocks=%0d pops=%0d, expected 0 1 4",
                     to, bd_cnt - bd0, pop_cnt - p0);
        end
        flush_buf();
    endtask

    task automatic test_underrun();
        int bd0, xd0, m0;
        bit to;
        block_size_i = 12'd32;
        model_words = 8;
        underrun_req = 5;
        load_buf(16);
        bd0 = bd_cnt; xd0 = xd_cnt; m0 = model_blk;
        do_start(16'd2);
        wait_xfer(xd0, to);
        underrun_req = 0;
        tests++;
        if (to || underrun_err_o !== 1'b1) begin
            fails++;
            $display("FAIL underrun_flag: timeout=%b underrun_err_o=%b, expected 0 1", to, underrun_err_o);
        end
        tests++;
        if (bd_cnt - bd0 != 0 || model_blk - m0 != 1) begin
            fails++;
            $display("FAIL underrun_end: block_done=%0d blocks_run=%0d, expected 0 1",
                     bd_cnt - bd0, model_blk - m0);
        end
        tests++;
        if (blocks_left_o !== 16'd1 || crc_err_o !== 1'b0) begin
            fails++;
            $display("FAIL underrun_state: blocks_left=%0d crc=%b, expected 1 0", blocks_left_o, crc_err_o);
        end
        flush_buf();
    endtask

    task automatic test_crc_error();
        int bd0, xd0;
        bit to;
        block_size_i = 12'd16;
        model_words = 4;
        load_buf(16);
        crc_block = model_blk + 2;
        bd0 = bd_cnt; xd0 = xd_cnt;
        do_start(16'd4);
        wait_xfer(xd0, to);
        crc_block = -1;
        tests++;
        if (to || crc_err_o !== 1'b1 || blocks_left_o !== 16'd2) begin
            fails++;
            $display("FAIL crc_stop: timeout=%b crc=%b blocks_left=%0d, expected 0 1 2",
                     to, crc_err_o, blocks_left_o);
        end
        tests++;
        if (bd_cnt - bd0 != 1 || xd_cnt - xd0 != 1 || underrun_err_o !== 1'b0) begin
            fails++;
            $display("FAIL crc_pulses: block_done=%0d xfer_done=%0d underrun=%b, expected 1 1 0",
                     bd_cnt - bd0, xd_cnt - xd0, underrun_err_o);
        end
        flush_buf();
        load_buf(4);
        bd0 = bd_cnt; xd0 = xd_cnt;
        do_start(16'd1);
        tests++;
        if (crc_err_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL crc_cleared: crc=%b busy=%b, expected 0 1", crc_err_o, busy_o);
        end
        wait_xfer(xd0, to);
        tests++;
        if (to || bd_cnt - bd0 != 1 || crc_err_o !== 1'b0) begin
            fails++;
            $display("FAIL crc_next_xfer: timeout=%b block_done=%0d crc=%b, expected 0 1 0",
                     to, bd_cnt - bd0, crc_err_o);
        end
        flush_buf();
    endtask

    task automatic test_open_ended_stop();
        int bd0, xd0, p0, l0, m0, n;
        bit to;
        block_size_i = 12'd16;
        model_words = 4;
        load_buf(20);
        bd0 = bd_cnt; xd0 = xd_cnt; p0 = pop_cnt; l0 = left_log.size(); m0 = model_blk;
        do_start(16'd0);
        n = 0;
        while (!(model_blk - m0 == 3 && req_in_blk >= 1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        wait_xfer(xd0, to);
        tests++;
        if (to || n >= 5000 || bd_cnt - bd0 != 3) begin
            fails++;
            $display("FAIL open_stop_blocks: timeout=%b block_done=%0d, expected 0 3", to | (n >= 5000), bd_cnt - bd0);
        end
        tests++;
        if (pop_cnt - p0 != 12 || xd_cnt - xd0 != 1) begin
            fails++;
            $display("FAIL open_stop_pops: pops=%0d xfer_done=%0d, expected 12 1", pop_cnt - p0, xd_cnt - xd0);
        end
        for (int i = l0; i < left_log.size(); i++) begin
            tests++;
            if (left_log[i] !== 16'd0) begin
                fails++;
                $display("FAIL open_blocks_left: got %0d, expected 0", left_log[i]);
            end
        end
        flush_buf();
    endtask

    task automatic test_reset_mid_active();
        int bd0, xd0, n;
        bit to;
        block_size_i = 12'd16;
        model_words = 4;
        load_buf(8);
        xd0 = xd_cnt;
        do_start(16'd2);
        n = 0;
        while (req_in_blk < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        model_abort = 1'b1;
        rst_i = 1'b1;
        @(negedge clk);
        tests++;
        if ({word_ready_o, dw_start_o, busy_o, block_done_o, xfer_done_o, crc_err_o,
             end_bit_err_o, underrun_err_o} !== 8'h00 || dw_data_o !== 32'h0 || blocks_left_o !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: busy=%b data=%h left=%0d, expected all 0",
                     busy_o, dw_data_o, blocks_left_o);
        end
        rst_i = 1'b0;
        n = 0;
        while (model_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        model_abort = 1'b0;
        tests++;
        if (xd_cnt - xd0 != 0 || model_busy) begin
            fails++;
            $display("FAIL mid_reset_no_xfer: xfer_done=%0d model_busy=%b, expected 0 0", xd_cnt - xd0, model_busy);
        end
        flush_buf();
        load_buf(4);
        bd0 = bd_cnt; xd0 = xd_cnt;
        do_start(16'd1);
        wait_xfer(xd0, to);
        tests++;
        if (to || bd_cnt - bd0 != 1 || blocks_left_o !== 16'd0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL mid_reset_restart: timeout=%b block_done=%0d left=%0d leftover=%0d, expected 0 1 0 0",
                     to, bd_cnt - bd0, blocks_left_o, exp_q.size());
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; block_count_i = 16'd0;
        block_size_i = 12'd16; model_words = 4; crc_block = -1; underrun_req = 0;
        test_reset();
        test_three_blocks();
        test_block_ready_late();
        test_underrun();
        test_crc_error();
        test_open_ended_stop();
        test_reset_mid_active();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
